vlsu_stride: RTL and testbench
==============================

Name: vlsu_stride

Overview:
- Parametrised vector load/store unit for VLEN-bit vector registers over the 32-bit scalar memory bus.
- Splits one vector access into NBEAT = VLEN/32 single-word beats, in either unit-stride or constant-stride mode.
- Sits between the vector register file / issue logic and the shared memory port.
- Adds to the 64-bit unit: back-to-back beats with no bubble, a misalignment error, and an optional element mask.

Parameters:
- VLEN, 128, vector register width in bits; multiple of 32, range 64..512.
- NBEAT, VLEN/32, derived element/beat count; not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request strobe; sampled only in IDLE
- is_store  in  1  0=load, 1=store
- strided  in  1  0=unit stride (byte step 4), 1=byte step = stride
- base_addr  in  32  start byte address, from scalar register
- stride  in  32  byte stride, two's complement, from scalar register
- store_data  in  VLEN  store source; also old vd contents for masked loads
- vmask  in  NBEAT  per-element enable; used only with VLSU_MASK_EN
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- err  out  1  high together with done when the access was rejected
- load_data  out  VLEN  load result; element i = bits [32i+31:32i]
- mem_addr  out  32  word address of the current beat
- mem_wdata  out  32  store word
- mem_wmask  out  4  4'b1111 on store beats, 4'b0000 on load beats
- mem_write  out  1  store beat flag
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted when high while mem_valid is high
- mem_resp_valid  in  1  load response valid
- mem_resp_rdata  in  32  load response data

Behaviour:
- Reset is asynchronous and active-low. On reset, every output is 0 and state returns to IDLE.
- Reset mid-transfer aborts immediately: no done, load_data cleared, mem_valid drops asynchronously.
- FSM states: IDLE, ISSUE, WAIT_RSP, FINISH.
- IDLE, start=1:
  - Latch all inputs; idx=0; addr=base_addr.
  - If base_addr[1:0]!=0, or strided=1 and stride[1:0]!=0: go to FINISH with err=1. No bus activity.
  - Otherwise go to ISSUE.
- ISSUE: mem_valid=1, mem_addr=addr, mem_write=is_store, mem_wdata=element idx. All outputs are held stable until mem_ready=1.
- Beat completion:
  - Store: completes on mem_ready.
  - Load: completes on mem_ready & mem_resp_valid in the same cycle.
  - Load with mem_ready but no response: drop mem_valid and go to WAIT_RSP. WAIT_RSP completes the beat on the first mem_resp_valid.
- mem_resp_valid is ignored in IDLE, in FINISH, and in ISSUE while mem_ready=0.
- On beat completion:
  - Load: capture the word into element idx.
  - idx += 1; addr += (strided ? stride : 4), modulo 2^32 (wrap-around allowed).
  - If idx was NBEAT-1, go to FINISH; else go to ISSUE with no idle cycle.
- FINISH: done=1 (and err if flagged) for exactly one cycle; load_data is updated in the same cycle for successful loads; return to IDLE.
- Stores and errors leave load_data unchanged.
- start outside IDLE is ignored.
- Latency with mem_ready and mem_resp_valid held high: done asserts NBEAT+1 cycles after the start cycle; mem_valid is high for NBEAT consecutive cycles.
- Beats are issued in ascending idx order. Responses arrive in order; at most one request is outstanding.

Optional Feature:
- Macro VLSU_MASK_EN.
- Defined:
  - Elements with vmask[i]=0 are skipped: no bus request, zero cycles spent. The address still advances by the step.
  - Masked load elements take the store_data element (undisturbed).
  - All-zero mask: FINISH on the cycle after start; done asserts with err=0.
- Undefined: vmask is ignored and every element is transferred.

Test Plan:
- Unit load: VLEN=128, base 0x100, ready=1, responses in the same cycle returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> addrs 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; done 5 cycles after start; load_data=0x44444444_33333333_22222222_11111111.
- Strided store: base 0x200, stride 16, store_data words A0..A3 -> addrs 0x200, 0x210, 0x220, 0x230; wdata A0..A3; wmask 1111; write=1; done, err=0.
- Negative stride with backpressure: base 0x40, stride -8 (0xFFFFFFF8), mem_ready low for 3 cycles on beat 1, response 2 cycles after ready -> addrs 0x40, 0x38, 0x30, 0x28; address held during the stall; correct data capture.
- Misalign: base 0x102, or stride 6 -> done+err on the cycle after start; mem_valid never asserted; load_data unchanged.
- Reset mid-op: rst_n low during beat 2 of a load -> all outputs 0 immediately; the next start runs a clean full transfer.
- VLSU_MASK_EN: vmask=4'b1010, load -> only addrs +4 and +12 requested; elements 0 and 2 equal store_data; done after 2 beats.

Source files
------------

// File: rtl/vlsu_stride.sv
// rtl/vlsu_stride.sv - vector load/store unit splitting VLEN-bit accesses into 32-bit beats (optional element mask: VLSU_MASK_EN)
module vlsu_stride #(
  parameter int VLEN  = 128,
  parameter int NBEAT = VLEN / 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic             strided,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      stride,
  input  logic [VLEN-1:0]  store_data,
  input  logic [NBEAT-1:0] vmask,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [VLEN-1:0]  load_data,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  output logic             mem_write,
  output logic             mem_valid,
  input  logic             mem_ready,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_rdata
);

  localparam int IW = $clog2(NBEAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, FINISH} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [31:0]      step_q;
  logic [NBEAT-1:0] mask_q;
  logic             st_q;
  logic [VLEN-1:0]  data_q;

  logic [31:0]      in_step;
  logic [NBEAT-1:0] in_mask;
  logic             misalign;
  logic             beat_done;
  logic [VLEN-1:0]  data_upd;

  logic [IW:0]      srch_from;
  logic [31:0]      srch_start;
  logic [31:0]      srch_step;
  logic [NBEAT-1:0] srch_mask;
  logic [31:0]      srch_acc;
  logic             srch_found;
  logic [IW-1:0]    srch_idx;
  logic [31:0]      srch_addr;

`ifdef VLSU_MASK_EN
  assign in_mask = vmask;
`else
  logic unused_vmask;
  assign in_mask      = '1;
  assign unused_vmask = ^vmask;
`endif

  assign in_step  = strided ? stride : 32'd4;
  assign misalign = (base_addr[1:0] != 2'b00) || (strided && (stride[1:0] != 2'b00));

  // A store beat completes on acceptance; a load beat needs its response too
  assign beat_done = ((state == ISSUE) && mem_ready && (st_q || mem_resp_valid)) ||
                     ((state == WAIT_RSP) && mem_resp_valid);

  // Working vector with the current load response merged into element idx
  always_comb begin
    data_upd = data_q;
    data_upd[{idx, 5'b0} +: 32] = mem_resp_rdata;
  end

  // Search origin: element 0 at start, otherwise the element after the current one
  always_comb begin
    if (state == IDLE) begin
      srch_from  = '0;
      srch_start = base_addr;
      srch_step  = in_step;
      srch_mask  = in_mask;
    end else begin
      srch_from  = {1'b0, idx} + (IW+1)'(1);
      srch_start = mem_addr + step_q;
      srch_step  = step_q;
      srch_mask  = mask_q;
    end
  end

  // Find the next enabled element, advancing the address past skipped ones
  always_comb begin
    srch_found = 1'b0;
    srch_idx   = '0;
    srch_addr  = '0;
    srch_acc   = srch_start;
    for (int i = 0; i < NBEAT; i++) begin
      if (i >= int'(srch_from)) begin
        if (!srch_found && srch_mask[i]) begin
          srch_found = 1'b1;
          srch_idx   = IW'(i);
          srch_addr  = srch_acc;
        end
        srch_acc = srch_acc + srch_step;
      end
    end
  end

  // Control FSM with registered bus and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      step_q    <= '0;
      mask_q    <= '0;
      st_q      <= 1'b0;
      data_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_write <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            st_q   <= is_store;
            step_q <= in_step;
            mask_q <= in_mask;
            data_q <= store_data;
            busy   <= 1'b1;
            if (misalign) begin
              state <= FINISH;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!srch_found) begin
              state <= FINISH;
              done  <= 1'b1;
              if (!is_store) load_data <= store_data;
            end else begin
              state     <= ISSUE;
              idx       <= srch_idx;
              mem_addr  <= srch_addr;
              mem_valid <= 1'b1;
              mem_write <= is_store;
              mem_wmask <= {4{is_store}};
              mem_wdata <= store_data[{srch_idx, 5'b0} +: 32];
            end
          end
        end
        ISSUE, WAIT_RSP: begin
          if (beat_done) begin
            if (!st_q) data_q <= data_upd;
            if (srch_found) begin
              state     <= ISSUE;
              idx       <= srch_idx;
              mem_addr  <= srch_addr;
              mem_valid <= 1'b1;
              mem_write <= st_q;
              mem_wmask <= {4{st_q}};
              mem_wdata <= data_q[{srch_idx, 5'b0} +: 32];
            end else begin
              state     <= FINISH;
              mem_valid <= 1'b0;
              mem_write <= 1'b0;
              mem_wmask <= 4'b0000;
              done      <= 1'b1;
              if (!st_q) load_data <= data_upd;
            end
          end else if ((state == ISSUE) && mem_ready) begin
            state     <= WAIT_RSP;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_wmask <= 4'b0000;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_stride.sv
// tb/tb_vlsu_stride.sv - scoreboard testbench for vlsu_stride
module tb_vlsu_stride;

  localparam int VLEN  = 128;
  localparam int NBEAT = VLEN / 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             is_store = 1'b0;
  logic             strided = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [31:0]      stride = '0;
  logic [VLEN-1:0]  store_data = '0;
  logic [NBEAT-1:0] vmask = '0;
  logic             busy, done, err;
  logic [VLEN-1:0]  load_data;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_wmask;
  logic             mem_write, mem_valid;
  logic             mem_ready = 1'b0;
  logic             mem_resp_valid = 1'b0;
  logic [31:0]      mem_resp_rdata = '0;

  int checks = 0;
  int errors = 0;
  logic [VLEN-1:0] model_ld = '0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] resp_q[$];

  vlsu_stride #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .strided(strided),
    .base_addr(base_addr), .stride(stride), .store_data(store_data), .vmask(vmask),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_write(mem_write), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_word(input logic [VLEN-1:0] v, input int i);
    logic [VLEN-1:0] t;
    t = v >> (32 * i);
    return t[31:0];
  endfunction

  function automatic logic [VLEN-1:0] put_word(input logic [VLEN-1:0] v, input int i, input logic [31:0] w);
    logic [VLEN-1:0] m;
    logic [VLEN-1:0] x;
    m = {{(VLEN-32){1'b0}}, 32'hFFFF_FFFF} << (32 * i);
    x = {{(VLEN-32){1'b0}}, w} << (32 * i);
    return (v & ~m) | x;
  endfunction

  task automatic run_access(input string name, input logic st, input logic sd,
                            input logic [31:0] base, input logic [31:0] strd,
                            input logic [VLEN-1:0] sdata, input logic [NBEAT-1:0] msk,
                            input logic [VLEN-1:0] words, input int stall_beat,
                            input int stall_n, input int rdly, input logic hold_start);
    logic             misal;
    logic [NBEAT-1:0] emask;
    logic [31:0]      step, a, pend_data;
    logic [VLEN-1:0]  exp_ld;
    int nb, n, beat, stall_left, pend_cnt, exp_lat;
    logic done_seen;
    misal = (base[1:0] != 2'b00) || (sd && (strd[1:0] != 2'b00));
`ifdef VLSU_MASK_EN
    emask = msk;
`else
    emask = '1;
`endif
    step   = sd ? strd : 32'd4;
    exp_ld = model_ld;
    nb     = 0;
    a      = base;
    exp_addr_q.delete(); exp_wdata_q.delete(); resp_q.delete();
    if (!misal) begin
      for (int i = 0; i < NBEAT; i++) begin
        if (emask[i]) begin
          exp_addr_q.push_back(a);
          exp_wdata_q.push_back(get_word(sdata, i));
          resp_q.push_back(get_word(words, i));
          if (!st) exp_ld = put_word(exp_ld, i, get_word(words, i));
          nb++;
        end else if (!st) begin
          exp_ld = put_word(exp_ld, i, get_word(sdata, i));
        end
        a = a + step;
      end
    end
    exp_lat = misal ? 1 : nb + 1;

    @(posedge clk); #1;
    start = 1'b1; is_store = st; strided = sd; base_addr = base; stride = strd;
    store_data = sdata; vmask = msk;
    n = 0; beat = 0; stall_left = stall_n; pend_cnt = 0; pend_data = '0; done_seen = 1'b0;
    while (!done_seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = hold_start && (n < 3);
      if (n == 1) begin
        base_addr = 32'hDEAD_BEE1; stride = 32'h3; store_data = ~sdata; vmask = ~msk;
      end
      mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h5A5A_5A5A;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = pend_data;
        end
      end else if (mem_valid) begin
        if (beat == stall_beat && stall_left > 0) begin
          stall_left--;
          mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
        end else begin
          mem_ready = 1'b1;
          if (!mem_write && resp_q.size() > 0) begin
            if (rdly == 0) begin
              mem_resp_valid = 1'b1; mem_resp_rdata = resp_q[0];
            end else begin
              pend_cnt = rdly; pend_data = resp_q[0];
            end
          end
          if (resp_q.size() > 0) void'(resp_q.pop_front());
          beat++;
        end
      end
      @(negedge clk);
      if (mem_valid) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_request: addr got %h want none", name, mem_addr);
        end else begin
          if (mem_addr !== exp_addr_q[0] || mem_write !== st || mem_wmask !== {4{st}} || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s request: addr/write/wmask/busy got %h/%b/%b/%b want %h/%b/%b/1",
                     name, mem_addr, mem_write, mem_wmask, busy, exp_addr_q[0], st, {4{st}});
          end
          if (st) begin
            checks++;
            if (mem_wdata !== exp_wdata_q[0]) begin
              errors++;
              $display("FAIL %s wdata: got %h want %h", name, mem_wdata, exp_wdata_q[0]);
            end
          end
          if (mem_ready) begin
            void'(exp_addr_q.pop_front());
            void'(exp_wdata_q.pop_front());
          end
        end
      end
      if (done) begin
        done_seen = 1'b1;
        checks++;
        if (err !== misal || load_data !== exp_ld) begin
          errors++;
          $display("FAIL %s result: err got %b want %b, load_data got %h want %h",
                   name, err, misal, load_data, exp_ld);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
          errors++;
          $display("FAIL %s beats: got %0d requests missing want 0", name, exp_addr_q.size());
        end
        if (stall_n == 0 && rdly == 0) begin
          checks++;
          if (n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
          end
        end
      end
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s timeout: done got 0 want 1", name);
    end
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done/mem_valid got %b/%b want 0/0", name, done, mem_valid);
    end
    model_ld = exp_ld;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, load_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs got %h want 0",
               {busy, done, err, mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, load_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ld = '0;
  endtask

  task automatic test_unit_load();
    run_access("unit_load", 1'b0, 1'b0, 32'h100, 32'h0, '0, '1,
               {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, -1, 0, 0, 1'b0);
  endtask

  task automatic test_strided_store();
    run_access("strided_store", 1'b1, 1'b1, 32'h200, 32'd16,
               {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, '1, '0, -1, 0, 0, 1'b1);
  endtask

  task automatic test_neg_stride_backpressure();
    run_access("neg_stride", 1'b0, 1'b1, 32'h40, 32'hFFFF_FFF8, '0, '1,
               {32'hD4D4_0004, 32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001}, 1, 3, 2, 1'b0);
  endtask

  task automatic test_misalign();
    run_access("misalign_base", 1'b0, 1'b0, 32'h102, 32'h0, '0, '1, '1, -1, 0, 0, 1'b0);
    run_access("misalign_stride", 1'b0, 1'b1, 32'h100, 32'd6, '0, '1, '1, -1, 0, 0, 1'b0);
    run_access("unit_ignores_stride", 1'b1, 1'b0, 32'h180, 32'd6,
               {32'h0D, 32'h0C, 32'h0B, 32'h0A}, '1, '0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_access("wrap_load", 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, '0, '1,
               {32'h0000_0D0D, 32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A}, -1, 0, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; strided = 1'b0; base_addr = 32'h500; vmask = '1;
    mem_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h508) begin
      errors++;
      $display("FAIL reset_mid_active: valid/addr got %b/%h want 1/00000508", mem_valid, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, load_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h want 0",
               {busy, done, err, mem_valid, mem_write, mem_wmask, mem_addr, mem_wdata, load_data});
    end
    mem_ready = 1'b0; mem_resp_valid = 1'b0;
    model_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_access("after_reset", 1'b0, 1'b0, 32'h600, 32'h0, '0, '1,
               {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001}, -1, 0, 0, 1'b0);
  endtask

  task automatic test_mask();
    run_access("mask_1010", 1'b0, 1'b0, 32'h300, 32'h0,
               {32'h5353_5353, 32'h5252_5252, 32'h5151_5151, 32'h5050_5050}, 4'b1010,
               {32'hEEEE_0003, 32'hEEEE_0002, 32'hEEEE_0001, 32'hEEEE_0000}, -1, 0, 0, 1'b0);
    run_access("mask_zero", 1'b0, 1'b1, 32'h400, 32'd8,
               {32'h6363_6363, 32'h6262_6262, 32'h6161_6161, 32'h6060_6060}, 4'b0000,
               {32'h1, 32'h2, 32'h3, 32'h4}, -1, 0, 0, 1'b0);
    run_access("mask_store_0110", 1'b1, 1'b1, 32'h800, 32'hFFFF_FFF0,
               {32'h7373_7373, 32'h7272_7272, 32'h7171_7171, 32'h7070_7070}, 4'b0110,
               '0, 0, 2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unit_load();
    test_strided_store();
    test_neg_stride_backpressure();
    test_misalign();
    test_wrap();
    test_reset_mid();
    test_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
